// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_CORE,
    OWN_DMA
  } owner_t;

  // Word size code of the rd_wr_mem load/store size encoding (LW/SW funct3).
  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with a zero flag; used for read latency and burst beats.
module arb_lat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates data memory between the core memory stage and a DMA/debug port.
// Optional DMA bursts are enabled with the DMEM_ARB_BURST_EN macro.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ack,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
`ifdef DMEM_ARB_BURST_EN
  input  logic [3:0]  dma_len,
`endif
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = 3;
  localparam int BW = $clog2(BURST_MAX);

  arb_state_t    state_reg, state_next;
  owner_t        owner_reg, grant_owner;
  logic          grant;
  logic [SW-1:0] starve_cnt_reg;
  logic          acc_we_reg;
  logic [2:0]    acc_size_reg;
  logic [31:0]   acc_addr_reg, acc_wdata_reg;
  logic [31:0]   core_rdata_reg, dma_rdata_reg;
  logic          done_pulse, rd_done;
  logic          lat_load, lat_dec, lat_done;
  logic          burst_act;
  logic [31:0]   dma_beat_addr;
  logic [1:0]    unused_addr_lsb;

  assign unused_addr_lsb = dma_addr[1:0];

  // Owner selection happens while IDLE so the access issues on the next cycle.
  always_comb begin
    grant       = 1'b0;
    grant_owner = OWN_CORE;
    if (state_reg == IDLE) begin
      if (burst_act) begin
        grant       = dma_req;
        grant_owner = OWN_DMA;
      end else if (core_req && dma_req) begin
        grant       = 1'b1;
        grant_owner = (starve_cnt_reg == SW'(STARVE_MAX)) ? OWN_DMA : OWN_CORE;
      end else if (core_req) begin
        grant       = 1'b1;
        grant_owner = OWN_CORE;
      end else if (dma_req) begin
        grant       = 1'b1;
        grant_owner = OWN_DMA;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 3'b000;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    done_pulse = 1'b0;
    rd_done    = 1'b0;
    lat_load   = 1'b0;
    lat_dec    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant) state_next = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = acc_we_reg;
        mem_size  = acc_size_reg;
        mem_addr  = acc_addr_reg;
        mem_wdata = acc_wdata_reg;
        if (acc_we_reg) begin
          done_pulse = 1'b1;
          state_next = IDLE;
        end else begin
          lat_load   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_done) begin
          done_pulse = 1'b1;
          rd_done    = 1'b1;
          state_next = IDLE;
        end else begin
          lat_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  arb_lat_counter #(.W(LW)) u_lat_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (lat_load),
    .load_val (LW'(MEM_LAT - 1)),
    .dec      (lat_dec),
    .done     (lat_done)
  );

  assign core_ack = done_pulse && (owner_reg == OWN_CORE);
  assign dma_ack  = done_pulse && (owner_reg == OWN_DMA);

  // Read data is forwarded in the ack cycle and held afterwards.
  assign core_rdata = (rd_done && owner_reg == OWN_CORE) ? mem_rdata : core_rdata_reg;
  assign dma_rdata  = (rd_done && owner_reg == OWN_DMA)  ? mem_rdata : dma_rdata_reg;

  // Gated by reset so the stall is also low while reset is held.
  assign core_stall = reset && core_req && !core_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_CORE;
      starve_cnt_reg <= '0;
      acc_we_reg     <= 1'b0;
      acc_size_reg   <= 3'b000;
      acc_addr_reg   <= 32'h0;
      acc_wdata_reg  <= 32'h0;
      core_rdata_reg <= 32'h0;
      dma_rdata_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        owner_reg     <= grant_owner;
        acc_we_reg    <= (grant_owner == OWN_CORE) ? core_we    : dma_we;
        acc_size_reg  <= (grant_owner == OWN_CORE) ? core_size  : SIZE_WORD;
        acc_addr_reg  <= (grant_owner == OWN_CORE) ? core_addr  : dma_beat_addr;
        acc_wdata_reg <= (grant_owner == OWN_CORE) ? core_wdata : dma_wdata;
      end
      if (rd_done && owner_reg == OWN_CORE) core_rdata_reg <= mem_rdata;
      if (rd_done && owner_reg == OWN_DMA)  dma_rdata_reg  <= mem_rdata;
      if (!dma_req || (grant && grant_owner == OWN_DMA)) begin
        starve_cnt_reg <= '0;
      end else if (grant && starve_cnt_reg != SW'(STARVE_MAX)) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

`ifdef DMEM_ARB_BURST_EN
  logic        burst_act_reg;
  logic [31:0] burst_addr_reg;
  logic        beat_load, beat_dec, beat_last;

  assign burst_act     = burst_act_reg;
  assign dma_beat_addr = burst_act_reg ? burst_addr_reg : {dma_addr[31:2], 2'b00};
  assign beat_load     = grant && (grant_owner == OWN_DMA) && !burst_act_reg;
  assign beat_dec      = dma_ack && burst_act_reg && !beat_last;

  // Counts remaining beats after the current one; zero marks the final beat.
  arb_lat_counter #(.W(BW)) u_beat_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (beat_load),
    .load_val (BW'(dma_len)),
    .dec      (beat_dec),
    .done     (beat_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burst_act_reg  <= 1'b0;
      burst_addr_reg <= 32'h0;
    end else begin
      if (beat_load) begin
        burst_act_reg <= 1'b1;
      end else if (dma_ack && beat_last) begin
        burst_act_reg <= 1'b0;
      end
      if (grant && grant_owner == OWN_DMA) burst_addr_reg <= dma_beat_addr + 32'd4;
    end
  end
`else
  logic [BW-1:0] unused_beats;

  assign unused_beats  = '0;
  assign burst_act     = 1'b0;
  assign dma_beat_addr = {dma_addr[31:2], 2'b00};
`endif

endmodule
